// File: rtl/upl_packet_buffer.sv
// rtl/upl_packet_buffer.sv - store-and-forward UPL packet buffer over a circular word RAM
module upl_packet_buffer #(
    parameter int ADDR_W        = 9,
    parameter int MAX_PKT_WORDS = 128,
    parameter int LEN_W         = 2
) (
    input  logic              pUPLGlobalClk,
    input  logic              Reset_n,
    input  logic [31:0]       pIn_Data,
    input  logic              pIn_Request,
    output logic              pIn_Ack,
    input  logic              pIn_Enable,
    output logic [31:0]       pOut_Data,
    output logic              pOut_Request,
    input  logic              pOut_Ack,
    output logic              pOut_Enable,
    output logic [15:0]       pStatus_PktCount,
    output logic [15:0]       pStatus_TruncCount,
    output logic [ADDR_W:0]   pStatus_Level
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int FIFO_D = 1 << LEN_W;
    localparam int CNT_W  = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_PKT_WORDS);
    localparam logic [CNT_W-1:0]  ONE_CNT = CNT_W'(1);
    localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W+1:0] MAX_X   = (ADDR_W+2)'(MAX_PKT_WORDS);
    localparam logic [LEN_W+1:0]  FIFO_X  = (LEN_W+2)'(FIFO_D);

    typedef enum logic [1:0] {IN_IDLE, IN_WAIT, IN_RECV} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_GAP, OUT_SEND} out_state_t;

    in_state_t  in_state, in_nxt;
    out_state_t out_state, out_nxt;

    logic [31:0]       mem [DEPTH];
    logic [CNT_W-1:0]  len_fifo [FIFO_D];
    logic [ADDR_W-1:0] wr_ptr_spec, wr_ptr_com, rd_ptr;
    logic [CNT_W-1:0]  in_cnt, out_cnt, commit_len;
    logic              trunc_flag, commit_valid, commit_trunc;
    logic [LEN_W-1:0]  fifo_wr, fifo_rd;
    logic [LEN_W:0]    fifo_cnt;
    logic [31:0]       rd_data;
    logic [ADDR_W+1:0] eff_level;
    logic [LEN_W+1:0]  fifo_used;
    logic              can_ack, ack_set, wr_en, drop, commit;
    logic              pop, rd_en, emit, last;

    // A commit still in its one-cycle pipeline stage already owns its words and FIFO slot
    assign eff_level = {1'b0, pStatus_Level} + (commit_valid ? (ADDR_W+2)'(commit_len) : '0);
    assign fifo_used = {1'b0, fifo_cnt} + (LEN_W+2)'(commit_valid);
    assign can_ack   = ((DEPTH_X - eff_level) >= MAX_X) && (fifo_used < FIFO_X);

    always_comb begin
        in_nxt  = in_state;
        ack_set = 1'b0;
        wr_en   = 1'b0;
        drop    = 1'b0;
        commit  = 1'b0;
        case (in_state)
            IN_IDLE: if (pIn_Request && can_ack) begin
                ack_set = 1'b1;
                in_nxt  = IN_WAIT;
            end
            IN_WAIT: if (pIn_Enable) begin
                wr_en  = 1'b1;
                in_nxt = IN_RECV;
            end
            IN_RECV: begin
                if (pIn_Enable) begin
                    if (in_cnt < MAX_CNT) wr_en = 1'b1;
                    else                  drop  = 1'b1;
                end else begin
                    commit = 1'b1;
                    in_nxt = IN_IDLE;
                end
            end
            default: in_nxt = IN_IDLE;
        endcase
    end

    always_ff @(posedge pUPLGlobalClk or negedge Reset_n) begin
        if (!Reset_n) begin
            in_state           <= IN_IDLE;
            pIn_Ack            <= 1'b0;
            wr_ptr_spec        <= '0;
            wr_ptr_com         <= '0;
            in_cnt             <= '0;
            trunc_flag         <= 1'b0;
            commit_valid       <= 1'b0;
            commit_len         <= '0;
            commit_trunc       <= 1'b0;
            pStatus_TruncCount <= '0;
        end else begin
            in_state     <= in_nxt;
            pIn_Ack      <= ack_set;
            commit_valid <= commit;
            if (ack_set) begin
                wr_ptr_spec <= wr_ptr_com;
                in_cnt      <= '0;
                trunc_flag  <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr_spec <= wr_ptr_spec + ADDR_W'(1);
                in_cnt      <= in_cnt + ONE_CNT;
            end
            if (drop) trunc_flag <= 1'b1;
            if (commit) begin
                wr_ptr_com   <= wr_ptr_spec;
                commit_len   <= in_cnt;
                commit_trunc <= trunc_flag;
            end
            if (commit_valid && commit_trunc) pStatus_TruncCount <= pStatus_TruncCount + 16'd1;
        end
    end

    // First word is fetched on pop so the SEND burst starts with data already registered
    always_comb begin
        out_nxt = out_state;
        pop     = 1'b0;
        rd_en   = 1'b0;
        emit    = 1'b0;
        last    = 1'b0;
        case (out_state)
            OUT_IDLE: if (fifo_cnt != '0) begin
                pop     = 1'b1;
                rd_en   = 1'b1;
                out_nxt = OUT_REQ;
            end
            OUT_REQ: if (pOut_Ack) out_nxt = OUT_GAP;
            OUT_GAP: out_nxt = OUT_SEND;
            OUT_SEND: begin
                emit = 1'b1;
                if (out_cnt == ONE_CNT) begin
                    last    = 1'b1;
                    out_nxt = OUT_IDLE;
                end else begin
                    rd_en = 1'b1;
                end
            end
            default: out_nxt = OUT_IDLE;
        endcase
    end

    always_ff @(posedge pUPLGlobalClk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_state        <= OUT_IDLE;
            out_cnt          <= '0;
            rd_ptr           <= '0;
            rd_data          <= '0;
            fifo_wr          <= '0;
            fifo_rd          <= '0;
            fifo_cnt         <= '0;
            pStatus_Level    <= '0;
            pStatus_PktCount <= '0;
        end else begin
            out_state <= out_nxt;
            if (pop) begin
                out_cnt <= len_fifo[fifo_rd];
                fifo_rd <= fifo_rd + LEN_W'(1);
            end else if (emit) begin
                out_cnt <= out_cnt - ONE_CNT;
            end
            if (rd_en) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            if (commit_valid) fifo_wr <= fifo_wr + LEN_W'(1);
            fifo_cnt      <= fifo_cnt + (LEN_W+1)'(commit_valid) - (LEN_W+1)'(pop);
            pStatus_Level <= pStatus_Level + (commit_valid ? (ADDR_W+1)'(commit_len) : '0)
                             - (ADDR_W+1)'(emit);
            if (last) pStatus_PktCount <= pStatus_PktCount + 16'd1;
        end
    end

    always_ff @(posedge pUPLGlobalClk) begin
        if (wr_en)        mem[wr_ptr_spec]  <= pIn_Data;
        if (commit_valid) len_fifo[fifo_wr] <= commit_len;
    end

    assign pOut_Request = (out_state == OUT_REQ);
    assign pOut_Enable  = (out_state == OUT_SEND);
    assign pOut_Data    = pOut_Enable ? rd_data : '0;

endmodule

// File: tb/tb_upl_packet_buffer.sv
// tb/tb_upl_packet_buffer.sv - scoreboard bench for upl_packet_buffer
module tb_upl_packet_buffer;

    localparam int MAXW       = 128;
    localparam int ACK_BUDGET = 3000;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic [31:0] pIn_Data = '0;
    logic        pIn_Request = 1'b0;
    logic        pIn_Ack;
    logic        pIn_Enable = 1'b0;
    logic [31:0] pOut_Data;
    logic        pOut_Request;
    logic        pOut_Ack = 1'b0;
    logic        pOut_Enable;
    logic [15:0] pkt_cnt, trunc_cnt;
    logic [9:0]  level;

    int checks = 0, failures = 0, cyc = 0;
    logic [31:0] exp_q[$];
    int          exp_len_q[$];
    logic [31:0] tx_words[$];
    int exp_pkts = 0, exp_trunc = 0;
    bit ack_en = 1'b0;
    int ack_delay = 0, req_age = 0;
    bit in_burst = 1'b0, ack_valid = 1'b0, mon_level = 1'b0;
    int burst_len = 0, ack_cyc = 0, commit_cyc = 0, mon_exp_len = 0;
    logic [31:0] mon_exp_w;

    upl_packet_buffer #(.ADDR_W(9), .MAX_PKT_WORDS(128), .LEN_W(2)) dut (
        .pUPLGlobalClk(clk),
        .Reset_n(Reset_n),
        .pIn_Data(pIn_Data),
        .pIn_Request(pIn_Request),
        .pIn_Ack(pIn_Ack),
        .pIn_Enable(pIn_Enable),
        .pOut_Data(pOut_Data),
        .pOut_Request(pOut_Request),
        .pOut_Ack(pOut_Ack),
        .pOut_Enable(pOut_Enable),
        .pStatus_PktCount(pkt_cnt),
        .pStatus_TruncCount(trunc_cnt),
        .pStatus_Level(level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream sink: checks output words against the scoreboard and answers Request
    always @(negedge clk) begin
        if (!Reset_n) begin
            in_burst  = 1'b0;
            burst_len = 0;
            ack_valid = 1'b0;
            pOut_Ack  = 1'b0;
            req_age   = 0;
        end else begin
            if (mon_level) begin
                checks++;
                if (level > 10'd512) begin
                    failures++;
                    $display("FAIL level_bound got=%0d max=512", level);
                end
            end
            if (ack_valid && cyc == ack_cyc + 1) begin
                checks++;
                if (pOut_Request !== 1'b0) begin
                    failures++;
                    $display("FAIL req_drop got=%b exp=0", pOut_Request);
                end
            end
            if (pOut_Enable === 1'b1) begin
                if (!in_burst) begin
                    in_burst  = 1'b1;
                    burst_len = 0;
                    checks++;
                    if (!ack_valid || cyc != ack_cyc + 2) begin
                        failures++;
                        $display("FAIL ack_to_data got_cycle=%0d exp_cycle=%0d", cyc, ack_cyc + 2);
                    end
                    ack_valid = 1'b0;
                end
                burst_len++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_word got=%08h exp=none", pOut_Data);
                end else begin
                    mon_exp_w = exp_q.pop_front();
                    if (pOut_Data !== mon_exp_w) begin
                        failures++;
                        $display("FAIL out_word got=%08h exp=%08h", pOut_Data, mon_exp_w);
                    end
                end
            end else if (in_burst) begin
                in_burst = 1'b0;
                checks++;
                if (exp_len_q.size() == 0) begin
                    failures++;
                    $display("FAIL burst_len got=%0d exp=none", burst_len);
                end else begin
                    mon_exp_len = exp_len_q.pop_front();
                    if (burst_len != mon_exp_len) begin
                        failures++;
                        $display("FAIL burst_len got=%0d exp=%0d", burst_len, mon_exp_len);
                    end
                end
            end
            if (ack_en && pOut_Request === 1'b1) begin
                pOut_Ack = (req_age >= ack_delay);
                req_age++;
            end else begin
                pOut_Ack = 1'b0;
                req_age  = 0;
            end
            if (pOut_Ack && pOut_Request === 1'b1) begin
                ack_cyc   = cyc;
                ack_valid = 1'b1;
            end
        end
    end

    task automatic send_pkt(input int n, input bit use_tx, output int wait_cycles, output bit ok);
        logic [31:0] w;
        ok = 1'b0;
        wait_cycles = 0;
        @(negedge clk);
        pIn_Request = 1'b1;
        while (wait_cycles < ACK_BUDGET) begin
            @(negedge clk);
            wait_cycles++;
            if (pIn_Ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        pIn_Request = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout got=none exp=ack within %0d cycles", ACK_BUDGET);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = use_tx ? tx_words[i] : $urandom();
            pIn_Enable = 1'b1;
            pIn_Data   = w;
            if (i < MAXW) exp_q.push_back(w);
            @(negedge clk);
        end
        pIn_Enable = 1'b0;
        pIn_Data   = '0;
        commit_cyc = cyc;
        exp_len_q.push_back(n > MAXW ? MAXW : n);
        exp_pkts++;
        if (n > MAXW) exp_trunc++;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_len_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout got=%0d_words_left exp=0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 10'd0) begin
            failures++;
            $display("FAIL drain_level got=%0d exp=0", level);
        end
        checks++;
        if (pkt_cnt !== 16'(exp_pkts)) begin
            failures++;
            $display("FAIL pkt_count got=%0d exp=%0d", pkt_cnt, exp_pkts);
        end
        checks++;
        if (trunc_cnt !== 16'(exp_trunc)) begin
            failures++;
            $display("FAIL trunc_count got=%0d exp=%0d", trunc_cnt, exp_trunc);
        end
    endtask

    task automatic test_reset();
        #3 Reset_n = 1'b0;
        #1;
        checks++;
        if ({pIn_Ack, pOut_Request, pOut_Enable} !== 3'b000 || pOut_Data !== 32'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b%b%b data=%08h exp=0", pIn_Ack, pOut_Request, pOut_Enable, pOut_Data);
        end
        checks++;
        if (pkt_cnt !== 16'd0 || trunc_cnt !== 16'd0 || level !== 10'd0) begin
            failures++;
            $display("FAIL reset_status got=%0d/%0d/%0d exp=0/0/0", pkt_cnt, trunc_cnt, level);
        end
        repeat (3) @(negedge clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pIn_Ack !== 1'b0 || pOut_Request !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b%b exp=00", pIn_Ack, pOut_Request);
        end
    endtask

    task automatic test_basic();
        int w, n;
        bit ok;
        ack_en = 1'b1;
        ack_delay = 3;
        tx_words = '{32'h0a000001, 32'h40004000, 32'h00080000, 32'hdeadbeef, 32'h12345678};
        send_pkt(5, 1'b1, w, ok);
        if (ok) begin
            checks++;
            if (w != 1) begin
                failures++;
                $display("FAIL ack_latency got=%0d exp=1", w);
            end
        end
        n = 0;
        while (pOut_Request !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc != commit_cyc + 3) begin
            failures++;
            $display("FAIL req_latency got=%0d exp=%0d", cyc - commit_cyc, 3);
        end
        wait_drain(200);
    endtask

    task automatic test_min_len();
        int w;
        bit ok;
        ack_delay = 0;
        tx_words = '{32'ha5a5a5a5};
        send_pkt(1, 1'b1, w, ok);
        wait_drain(100);
    endtask

    task automatic test_truncation();
        int w;
        bit ok;
        send_pkt(130, 1'b0, w, ok);
        wait_drain(500);
    endtask

    task automatic test_back_pressure();
        int w;
        bit ok, got_ack;
        ack_en = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(128, 1'b0, w, ok);
        @(negedge clk);
        pIn_Request = 1'b1;
        got_ack = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pIn_Ack === 1'b1) got_ack = 1'b1;
        end
        checks++;
        if (got_ack) begin
            failures++;
            $display("FAIL full_ack got=1 exp=0");
        end
        checks++;
        if (level !== 10'd512) begin
            failures++;
            $display("FAIL full_level got=%0d exp=512", level);
        end
        ack_en = 1'b1;
        send_pkt(128, 1'b0, w, ok);
        wait_drain(5000);
    endtask

    task automatic test_wrap();
        int w;
        bit ok;
        ack_en = 1'b1;
        ack_delay = 0;
        mon_level = 1'b1;
        for (int p = 0; p < 20; p++) send_pkt(100, 1'b0, w, ok);
        wait_drain(5000);
        mon_level = 1'b0;
    endtask

    task automatic reset_now();
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({pIn_Ack, pOut_Request, pOut_Enable} !== 3'b000 || pOut_Data !== 32'd0 ||
            level !== 10'd0 || pkt_cnt !== 16'd0 || trunc_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b data=%08h lvl=%0d pkt=%0d exp=all0",
                     pIn_Ack, pOut_Request, pOut_Enable, pOut_Data, level, pkt_cnt);
        end
        pIn_Enable  = 1'b0;
        pIn_Request = 1'b0;
        pIn_Data    = '0;
        exp_q.delete();
        exp_len_q.delete();
        exp_pkts  = 0;
        exp_trunc = 0;
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (level !== 10'd0) begin
            failures++;
            $display("FAIL level_after_reset got=%0d exp=0", level);
        end
    endtask

    task automatic test_reset_mid();
        int w, n;
        bit ok;
        @(negedge clk);
        pIn_Request = 1'b1;
        n = 0;
        while (pIn_Ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        pIn_Request = 1'b0;
        for (int i = 0; i < 49; i++) begin
            pIn_Enable = 1'b1;
            pIn_Data   = $urandom();
            @(negedge clk);
        end
        pIn_Data = 32'hcafe0050;
        reset_now();

        ack_en = 1'b0;
        send_pkt(20, 1'b0, w, ok);
        n = 0;
        while (pOut_Request !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ack_en = 1'b1;
        n = 0;
        while (pOut_Enable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        reset_now();

        tx_words = '{32'h11111111, 32'h22222222, 32'h33333333};
        send_pkt(3, 1'b1, w, ok);
        wait_drain(100);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_len();
        test_truncation();
        test_back_pressure();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/upl_packet_buffer.md
# upl_packet_buffer

Store-and-forward packet buffer for the UDP/IP core's UPL streaming interface (Request/Ack/Enable/Data, 32-bit). It accepts complete packets from a UPL source such as a UDP receive port, holds them in a circular word RAM, and replays each one unchanged to a UPL sink such as a UDP send port. It decouples receive bursts from send back-pressure, so the send side never sees a partial packet. It is instantiated between `pUdpNReceive_*` and `pUdpNSend_*` in place of a direct wire loopback.

## Interface
Parameters:
- `ADDR_W`, 9: RAM address width; capacity is 2^ADDR_W words.
- `MAX_PKT_WORDS`, 128: maximum stored packet length in words, including header words. Must satisfy `MAX_PKT_WORDS <= 2^ADDR_W`.
- `LEN_W`, 2: packet-length FIFO depth is 2^LEN_W entries.

Ports:
- `pUPLGlobalClk`, in, 1: single clock.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `pIn_Data`, in, 32: input word.
- `pIn_Request`, in, 1: upstream requests to send a packet.
- `pIn_Ack`, out, 1: grant pulse to upstream.
- `pIn_Enable`, in, 1: input word valid.
- `pOut_Data`, out, 32: output word.
- `pOut_Request`, out, 1: request to downstream.
- `pOut_Ack`, in, 1: grant from downstream.
- `pOut_Enable`, out, 1: output word valid.
- `pStatus_PktCount`, out, 16: packets forwarded; wraps.
- `pStatus_TruncCount`, out, 16: packets truncated; wraps.
- `pStatus_Level`, out, ADDR_W+1: committed, unread words in the RAM.

## Operation
- **Packet framing.** A packet is one contiguous run of `pIn_Enable`-high cycles after an Ack. It ends on the first cycle `pIn_Enable` is low. Contents, including header words, are opaque and are forwarded bit-exact.
- **Input FSM.**
  - IN_IDLE: when `pIn_Request` is high, free words ≥ `MAX_PKT_WORDS`, and the length FIFO is not full, pulse `pIn_Ack` for one cycle and go to IN_WAIT.
  - IN_WAIT: stay until `pIn_Enable` is high. There is no timeout.
  - IN_RECV: write one word per Enable cycle at the speculative write pointer. Words beyond `MAX_PKT_WORDS` are discarded and the packet's truncate flag is set.
  - On Enable low: commit. Push the stored word count (1..`MAX_PKT_WORDS`) into the length FIFO, copy the speculative write pointer to the committed write pointer, increment `pStatus_TruncCount` if the flag is set, and return to IN_IDLE.
- **Output FSM.**
  - OUT_IDLE: when the length FIFO is non-empty, pop the length into a down-counter, issue the RAM read of the first word, and go to OUT_REQ.
  - OUT_REQ: hold `pOut_Request` high until `pOut_Ack` is sampled high.
  - OUT_GAP: one cycle with Request and Enable low.
  - OUT_SEND: drive `pOut_Enable` high for exactly N consecutive cycles with the RAM words in order. After the last word, increment `pStatus_PktCount` and return to OUT_IDLE.
- **Pointers.** Read and write pointers are ADDR_W bits and wrap modulo 2^ADDR_W.
  - Free space is 2^ADDR_W − `pStatus_Level`.
  - The read side only ever sees committed words.
- **Level update.** `pStatus_Level` = committed words − words read. A commit and a read in the same cycle update it by (+N − 1) in one step.
- **Ordering.** Packets leave in arrival order with no reordering or gaps.
- **Reset.** Asserting reset mid-operation discards every stored and partial packet.

## Timing
- **Reset values.** All outputs are 0: `pIn_Ack`, `pOut_Request`, `pOut_Enable`, `pOut_Data`, all counters and `pStatus_Level`. All pointers and the length FIFO are emptied. Both FSMs are idle.
- **Ack latency.** `pIn_Ack` rises the cycle after `pIn_Request` is sampled high, if space is available.
- **Commit latency.** The Enable-low cycle is the commit edge. `pStatus_Level` and the FIFO count update on the following clock edge.
- **Output request latency.** `pOut_Request` rises 2 cycles after the commit edge if OUT_IDLE.
- **Ack to data.** If `pOut_Ack` is sampled high at cycle T:
  - `pOut_Request` is low at T+1.
  - `pOut_Enable` is high for cycles T+2 through T+1+N.
- **RAM.** Synchronous read with 1-cycle latency. The next word is prefetched so Enable never bubbles.
- **Throughput.** Input and output run concurrently, one word per cycle each.

## Test plan
- **Basic forward.** Send the 5-word packet 0x0a000001, 0x40004000, 0x00080000, 0xdeadbeef, 0x12345678 with `pOut_Ack` responding 3 cycles after Request rises. Required response: Enable high for exactly 5 consecutive cycles starting 2 cycles after the Ack cycle, with identical words; `pStatus_PktCount`=1; `pStatus_Level` returns to 0.
- **Back-pressure and full.** With `ADDR_W`=9, `MAX_PKT_WORDS`=128 and `pOut_Ack` held low, send five 128-word packets. Required response: four Acks are issued and the fifth Request gets no Ack; `pStatus_Level`=512. Then release Ack: the four packets come out in order, and the fifth is acked once 128 words are freed.
- **Truncation.** A 130-word packet produces 128 output words equal to the first 128 input words, and `pStatus_TruncCount`=1.
- **Wrap and concurrency.** Stream 20 packets of 100 words while the output Acks immediately, so pointers wrap past 511. Required response: data is bit-exact, and `pStatus_Level` is never negative and never exceeds 512.
- **Minimum length.** A 1-word packet 0xa5a5a5a5 produces a single Enable cycle carrying that word.
- **Reset mid-packet.** Assert `Reset_n`=0 during the 50th word of input and again mid-output. Required response: every output is 0 immediately; after release, `pStatus_Level`=0; the next 3-word packet forwards correctly.
